// File: rtl/asrv32_trap_ctrl.sv
// Writeback-stage trap sequencer: arbitrates exceptions, interrupts and MRET,
// strobes trap entry/return and holds the pipeline while it drains. Macro: ASRV32_INTERRUPT_EN.
module asrv32_trap_ctrl #(
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] PC_RESET     = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ce,
    input  logic        i_stall,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_fault_addr,
    input  logic        i_is_inst_illegal,
    input  logic        i_is_ecall,
    input  logic        i_is_ebreak,
    input  logic        i_is_mret,
    input  logic        i_instr_addr_misaligned,
    input  logic        i_load_addr_misaligned,
    input  logic        i_store_addr_misaligned,
    input  logic        i_mie,
    input  logic        i_meie,
    input  logic        i_mtie,
    input  logic        i_msie,
    input  logic        i_meip,
    input  logic        i_mtip,
    input  logic        i_msip,
    output logic        o_go_to_trap,
    output logic        o_return_from_trap,
    output logic        o_csr_wr,
    output logic [31:0] o_mcause,
    output logic [31:0] o_mepc,
    output logic [31:0] o_mtval,
    output logic        o_stall
);

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [31:0] CAUSE_INSTR_MISALIGN = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL        = 32'd2;
    localparam logic [31:0] CAUSE_EBREAK         = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGN  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGN = 32'd6;
    localparam logic [31:0] CAUSE_ECALL          = 32'd11;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_TRAP_ENTER = 2'd1,
        S_RETURN     = 2'd2,
        S_DRAIN      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      mcause_q, mcause_d;
    logic [31:0]      mepc_q, mepc_d;
    logic [31:0]      mtval_q, mtval_d;

    logic        sample_en;
    logic        exc_any;
    logic [31:0] exc_cause;
    logic [31:0] exc_tval;
    logic        irq_any;
    logic [31:0] irq_cause;
    logic        trap_take;
    logic        ret_take;

    assign sample_en = (state_q == S_IDLE) && i_ce && !i_stall;

    assign exc_any = i_instr_addr_misaligned | i_is_inst_illegal | i_is_ebreak |
                     i_is_ecall | i_load_addr_misaligned | i_store_addr_misaligned;

    // Fixed exception priority; only the winning source supplies mtval.
    always_comb begin
        exc_cause = 32'd0;
        exc_tval  = 32'd0;
        if (i_instr_addr_misaligned) begin
            exc_cause = CAUSE_INSTR_MISALIGN;
            exc_tval  = i_fault_addr;
        end else if (i_is_inst_illegal) begin
            exc_cause = CAUSE_ILLEGAL;
            exc_tval  = i_instr;
        end else if (i_is_ebreak) begin
            exc_cause = CAUSE_EBREAK;
        end else if (i_is_ecall) begin
            exc_cause = CAUSE_ECALL;
        end else if (i_load_addr_misaligned) begin
            exc_cause = CAUSE_LOAD_MISALIGN;
            exc_tval  = i_fault_addr;
        end else if (i_store_addr_misaligned) begin
            exc_cause = CAUSE_STORE_MISALIGN;
            exc_tval  = i_fault_addr;
        end
    end

`ifdef ASRV32_INTERRUPT_EN
    logic irq_mei;
    logic irq_msi;
    logic irq_mti;

    assign irq_mei = i_meip & i_meie;
    assign irq_msi = i_msip & i_msie;
    assign irq_mti = i_mtip & i_mtie;
    assign irq_any = i_mie & ~exc_any & (irq_mei | irq_msi | irq_mti);

    always_comb begin
        irq_cause = 32'd0;
        if (irq_mei) begin
            irq_cause = 32'h8000_000B;
        end else if (irq_msi) begin
            irq_cause = 32'h8000_0003;
        end else if (irq_mti) begin
            irq_cause = 32'h8000_0007;
        end
    end
`else
    logic unused_irq_inputs;

    assign unused_irq_inputs = ^{i_mie, i_meie, i_mtie, i_msie, i_meip, i_mtip, i_msip};
    assign irq_any   = 1'b0;
    assign irq_cause = 32'd0;
`endif

    // An interrupt pending on an MRET instruction is taken as a trap instead of returning.
    assign trap_take = sample_en & (exc_any | irq_any);
    assign ret_take  = sample_en & i_is_mret & ~exc_any & ~irq_any;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcause_q <= 32'd0;
            mepc_q   <= PC_RESET;
            mtval_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcause_q <= mcause_d;
            mepc_q   <= mepc_d;
            mtval_q  <= mtval_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (trap_take) begin
                    state_d = S_TRAP_ENTER;
                end else if (ret_take) begin
                    state_d = S_RETURN;
                end
            end
            S_TRAP_ENTER, S_RETURN: begin
                if (FLUSH_CYCLES > 0) begin
                    state_d = S_DRAIN;
                    cnt_d   = FLUSH_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (cnt_q <= CNT_ONE) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // CSR values are captured on the sample edge so they are valid alongside the strobe.
    always_comb begin
        mcause_d = mcause_q;
        mepc_d   = mepc_q;
        mtval_d  = mtval_q;
        if (trap_take) begin
            mepc_d = i_pc;
            if (exc_any) begin
                mcause_d = exc_cause;
                mtval_d  = exc_tval;
            end else begin
                mcause_d = irq_cause;
                mtval_d  = 32'd0;
            end
        end
    end

    always_comb begin
        o_go_to_trap       = 1'b0;
        o_return_from_trap = 1'b0;
        o_csr_wr           = 1'b0;
        o_stall            = 1'b1;
        case (state_q)
            S_IDLE:       o_stall = 1'b0;
            S_TRAP_ENTER: begin
                o_go_to_trap = 1'b1;
                o_csr_wr     = 1'b1;
            end
            S_RETURN:     o_return_from_trap = 1'b1;
            default:      o_stall = 1'b1;
        endcase
    end

    assign o_mcause = mcause_q;
    assign o_mepc   = mepc_q;
    assign o_mtval  = mtval_q;

endmodule

// File: tb/tb_asrv32_trap_ctrl.sv
// Bench for asrv32_trap_ctrl: FLUSH_CYCLES=1 and =0 instances on shared stimulus,
// table vectors, directed corner sequences and random traffic against a cycle model.
module tb_asrv32_trap_ctrl;

`ifdef ASRV32_INTERRUPT_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam logic [31:0] PCR = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst, ce, stl;
    logic [31:0] pc, instr, fault;
    logic        ill, ecall, ebreak, mret, iam, lam, sam;
    logic        mie, meie, mtie, msie, meip, mtip, msip;

    logic [1:0]  go_o, ret_o, wr_o, stall_o;
    logic [31:0] cause_o [2];
    logic [31:0] epc_o   [2];
    logic [31:0] tval_o  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    asrv32_trap_ctrl #(.FLUSH_CYCLES(1), .PC_RESET(PCR)) u_f1 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_stall(stl), .i_pc(pc), .i_instr(instr),
        .i_fault_addr(fault), .i_is_inst_illegal(ill), .i_is_ecall(ecall),
        .i_is_ebreak(ebreak), .i_is_mret(mret), .i_instr_addr_misaligned(iam),
        .i_load_addr_misaligned(lam), .i_store_addr_misaligned(sam), .i_mie(mie),
        .i_meie(meie), .i_mtie(mtie), .i_msie(msie), .i_meip(meip), .i_mtip(mtip),
        .i_msip(msip), .o_go_to_trap(go_o[0]), .o_return_from_trap(ret_o[0]),
        .o_csr_wr(wr_o[0]), .o_mcause(cause_o[0]), .o_mepc(epc_o[0]),
        .o_mtval(tval_o[0]), .o_stall(stall_o[0])
    );

    asrv32_trap_ctrl #(.FLUSH_CYCLES(0), .PC_RESET(PCR)) u_f0 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_stall(stl), .i_pc(pc), .i_instr(instr),
        .i_fault_addr(fault), .i_is_inst_illegal(ill), .i_is_ecall(ecall),
        .i_is_ebreak(ebreak), .i_is_mret(mret), .i_instr_addr_misaligned(iam),
        .i_load_addr_misaligned(lam), .i_store_addr_misaligned(sam), .i_mie(mie),
        .i_meie(meie), .i_mtie(mtie), .i_msie(msie), .i_meip(meip), .i_mtip(mtip),
        .i_msip(msip), .o_go_to_trap(go_o[1]), .o_return_from_trap(ret_o[1]),
        .o_csr_wr(wr_o[1]), .o_mcause(cause_o[1]), .o_mepc(epc_o[1]),
        .o_mtval(tval_o[1]), .o_stall(stall_o[1])
    );

    // Reference model: remaining busy cycles per instance, no state encoding.
    bit          m_go [2], m_ret [2], m_wr [2], m_stall [2];
    logic [31:0] m_cause [2], m_epc [2], m_tval [2];
    int          m_rem [2];

    function automatic int flush_of(int k);
        return (k == 0) ? 1 : 0;
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[f%0d]: got %h want %h at %0t", name, flush_of(k), act, exp, $time);
        end
    endtask

    function automatic void cause_of(output bit take, output logic [31:0] c, output logic [31:0] v);
        take = 1'b1;
        v    = 32'd0;
        c    = 32'd0;
        if (iam)             begin c = 0;  v = fault; end
        else if (ill)        begin c = 2;  v = instr; end
        else if (ebreak)     c = 3;
        else if (ecall)      c = 11;
        else if (lam)        begin c = 4;  v = fault; end
        else if (sam)        begin c = 6;  v = fault; end
        else if (IRQ_EN && mie && meip && meie) c = 32'h8000_000B;
        else if (IRQ_EN && mie && msip && msie) c = 32'h8000_0003;
        else if (IRQ_EN && mie && mtip && mtie) c = 32'h8000_0007;
        else take = 1'b0;
    endfunction

    task automatic model_step();
        bit          take;
        logic [31:0] c, v;
        cause_of(take, c, v);
        for (int k = 0; k < 2; k++) begin
            m_go[k] = 0; m_ret[k] = 0; m_wr[k] = 0;
            if (rst) begin
                m_stall[k] = 0; m_rem[k] = 0;
                m_cause[k] = 0; m_tval[k] = 0; m_epc[k] = PCR;
            end else if (m_stall[k]) begin
                if (m_rem[k] > 0) begin
                    m_rem[k]--;
                end else begin
                    m_stall[k] = 0;
                end
            end else if (ce && !stl) begin
                if (take) begin
                    m_go[k] = 1; m_wr[k] = 1; m_stall[k] = 1; m_rem[k] = flush_of(k);
                    m_cause[k] = c; m_tval[k] = v; m_epc[k] = pc;
                end else if (mret) begin
                    m_ret[k] = 1; m_stall[k] = 1; m_rem[k] = flush_of(k);
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("go", k, 32'(go_o[k]), 32'(m_go[k]));
            check("ret", k, 32'(ret_o[k]), 32'(m_ret[k]));
            check("csr_wr", k, 32'(wr_o[k]), 32'(m_wr[k]));
            check("stall", k, 32'(stall_o[k]), 32'(m_stall[k]));
            check("mcause", k, cause_o[k], m_cause[k]);
            check("mepc", k, epc_o[k], m_epc[k]);
            check("mtval", k, tval_o[k], m_tval[k]);
        end
    endtask

    task automatic clear_flags();
        ill = 0; ecall = 0; ebreak = 0; mret = 0; iam = 0; lam = 0; sam = 0;
        mie = 0; meie = 0; mtie = 0; msie = 0; meip = 0; mtip = 0; msip = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && stall_o != 2'b00; i++) tick();
        check("idle_timeout", 0, 32'(stall_o), 32'd0);
    endtask

    // exc = {iam, ill, ebreak, ecall, lam, sam, mret}; en/pend = {mei, msi, mti}
    typedef struct {
        logic [6:0]  exc;
        logic        ie;
        logic [2:0]  en;
        logic [2:0]  pend;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] fault;
        int          kind;   // 0 none, 1 trap, 2 return
        logic [31:0] cause;
        logic [31:0] tval;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(logic [6:0] exc, logic ie, logic [2:0] en, logic [2:0] pend,
                                logic [31:0] p, logic [31:0] ins, logic [31:0] f, int kind,
                                logic [31:0] c, logic [31:0] v);
        vec_t t;
        t.exc = exc; t.ie = ie; t.en = en; t.pend = pend; t.pc = p; t.instr = ins;
        t.fault = f; t.kind = kind; t.cause = c; t.tval = v;
        return t;
    endfunction

    initial begin
        int irq_kind;
        irq_kind = IRQ_EN ? 1 : 0;
        tbl[0]  = mk(7'b0001000, 0, 3'b000, 3'b000, 32'h100, 32'h1, 32'h9, 1, 11, 0);
        tbl[1]  = mk(7'b0100100, 0, 3'b000, 3'b000, 32'h104, 32'hFFFF_FFFF, 32'h123, 1, 2, 32'hFFFF_FFFF);
        tbl[2]  = mk(7'b1100000, 0, 3'b000, 3'b000, 32'h108, 32'hABCD, 32'h2002, 1, 0, 32'h2002);
        tbl[3]  = mk(7'b0011000, 0, 3'b000, 3'b000, 32'h10C, 32'h5, 32'h77, 1, 3, 0);
        tbl[4]  = mk(7'b0000110, 0, 3'b000, 3'b000, 32'h110, 32'h6, 32'h33, 1, 4, 32'h33);
        tbl[5]  = mk(7'b0000010, 0, 3'b000, 3'b000, 32'h114, 32'h7, 32'h47, 1, 6, 32'h47);
        tbl[6]  = mk(7'b0000001, 0, 3'b000, 3'b000, 32'h118, 32'h8, 32'h0, 2, 0, 0);
        tbl[7]  = mk(7'b0001001, 0, 3'b000, 3'b000, 32'h11C, 32'h9, 32'h0, 1, 11, 0);
        tbl[8]  = mk(7'b0000000, 1, 3'b111, 3'b101, 32'h200, 32'h0, 32'h0, irq_kind, 32'h8000_000B, 0);
        tbl[9]  = mk(7'b0000000, 1, 3'b111, 3'b011, 32'h204, 32'h0, 32'h0, irq_kind, 32'h8000_0003, 0);
        tbl[10] = mk(7'b0000000, 1, 3'b111, 3'b001, 32'h208, 32'h0, 32'h0, irq_kind, 32'h8000_0007, 0);
        tbl[11] = mk(7'b0000000, 0, 3'b111, 3'b111, 32'h20C, 32'h0, 32'h0, 0, 0, 0);
        tbl[12] = mk(7'b0000000, 1, 3'b011, 3'b101, 32'h210, 32'h0, 32'h0, irq_kind, 32'h8000_0007, 0);
        tbl[13] = mk(7'b0010000, 1, 3'b111, 3'b111, 32'h214, 32'h0, 32'h0, 1, 3, 0);
        tbl[14] = mk(7'b0000000, 0, 3'b000, 3'b000, 32'h218, 32'h0, 32'h0, 0, 0, 0);

        rst = 1; ce = 0; stl = 0; pc = 0; instr = 0; fault = 0;
        clear_flags();
        tick();
        tick();
        check("rst_stall", 0, 32'(stall_o[0]), 0);
        check("rst_mepc", 0, epc_o[0], PCR);
        check("rst_mcause", 0, cause_o[0], 0);
        check("rst_go", 0, 32'(go_o[0]), 0);
        rst = 0; ce = 1;
        tick();
        $display("txn reset done");

        // ecall at 0x100: one-cycle strobe, stall for 1+FLUSH cycles
        ecall = 1; pc = 32'h100;
        tick();
        clear_flags();
        check("ecall_go", 0, 32'(go_o[0]), 1);
        check("ecall_wr", 0, 32'(wr_o[0]), 1);
        check("ecall_cause", 0, cause_o[0], 11);
        check("ecall_mepc", 0, epc_o[0], 32'h100);
        check("ecall_mtval", 0, tval_o[0], 0);
        tick();
        check("ecall_drain_stall", 0, 32'(stall_o[0]), 1);
        check("ecall_drain_go", 0, 32'(go_o[0]), 0);
        tick();
        check("ecall_end_stall", 0, 32'(stall_o[0]), 0);
        $display("txn ecall pc=100 cause=%0d", cause_o[0]);

        for (int i = 0; i < 15; i++) begin
            wait_idle();
            {iam, ill, ebreak, ecall, lam, sam, mret} = tbl[i].exc;
            mie = tbl[i].ie;
            {meie, msie, mtie} = tbl[i].en;
            {meip, msip, mtip} = tbl[i].pend;
            pc = tbl[i].pc; instr = tbl[i].instr; fault = tbl[i].fault;
            tick();
            clear_flags();
            check("vec_go", 0, 32'(go_o[0]), 32'(tbl[i].kind == 1));
            check("vec_ret", 0, 32'(ret_o[0]), 32'(tbl[i].kind == 2));
            check("vec_wr", 0, 32'(wr_o[0]), 32'(tbl[i].kind == 1));
            if (tbl[i].kind == 1) begin
                check("vec_cause", 0, cause_o[0], tbl[i].cause);
                check("vec_mtval", 0, tval_o[0], tbl[i].tval);
                check("vec_mepc", 0, epc_o[0], tbl[i].pc);
            end
            $display("txn vec%0d kind=%0d cause=%h mtval=%h", i, tbl[i].kind, cause_o[0], tval_o[0]);
        end
        wait_idle();

        // MEI and MTI together; MTI follows once MEI drops
        mie = 1; meie = 1; mtie = 1; meip = 1; mtip = 1; pc = 32'h200;
        tick();
        check("irq_go", 0, 32'(go_o[0]), 32'(IRQ_EN));
        if (IRQ_EN) begin
            check("irq_cause", 0, cause_o[0], 32'h8000_000B);
            check("irq_mepc", 0, epc_o[0], 32'h200);
        end
        meip = 0; pc = 32'h204;
        tick();
        tick();
        tick();
        check("irq2_go", 0, 32'(go_o[0]), 32'(IRQ_EN));
        if (IRQ_EN) check("irq2_cause", 0, cause_o[0], 32'h8000_0007);
        clear_flags();
        wait_idle();
        $display("txn irq mei+mti cause=%h", cause_o[0]);

        // MRET held behind a 3-cycle downstream stall
        mret = 1; stl = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mret_blocked", 0, 32'(ret_o[0]), 0);
            check("mret_blocked_stall", 0, 32'(stall_o[0]), 0);
        end
        stl = 0;
        tick();
        mret = 0;
        check("mret_pulse", 0, 32'(ret_o[0]), 1);
        check("mret_wr", 0, 32'(wr_o[0]), 0);
        tick();
        check("mret_drain", 0, 32'(stall_o[0]), 1);
        check("mret_once", 0, 32'(ret_o[0]), 0);
        tick();
        check("mret_done", 0, 32'(stall_o[0]), 0);
        $display("txn mret after stall");

        // reset while draining
        ecall = 1; pc = 32'h300;
        tick();
        ecall = 0;
        tick();
        check("pre_rst_drain", 0, 32'(stall_o[0]), 1);
        rst = 1;
        tick();
        rst = 0;
        check("rst_drain_stall", 0, 32'(stall_o[0]), 0);
        check("rst_drain_mepc", 0, epc_o[0], PCR);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_strobe", 0, 32'(go_o[0] | ret_o[0]), 0);
        end
        $display("txn reset in drain");

        // FLUSH_CYCLES=0: ebreak then back-to-back ecall
        ebreak = 1; pc = 32'h40;
        tick();
        check("f0_go", 1, 32'(go_o[1]), 1);
        check("f0_cause", 1, cause_o[1], 3);
        check("f0_stall", 1, 32'(stall_o[1]), 1);
        ebreak = 0; ecall = 1; pc = 32'h44;
        tick();
        check("f0_stall_one", 1, 32'(stall_o[1]), 0);
        check("f0_ignored", 1, 32'(go_o[1]), 0);
        tick();
        check("f0_b2b_go", 1, 32'(go_o[1]), 1);
        check("f0_b2b_cause", 1, cause_o[1], 11);
        check("f0_b2b_mepc", 1, epc_o[1], 32'h44);
        clear_flags();
        wait_idle();
        $display("txn flush0 ebreak+ecall");

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            ce = ($urandom_range(0, 9) != 0);
            stl = ($urandom_range(0, 4) == 0);
            pc = $urandom; instr = $urandom; fault = $urandom;
            ill = ($urandom_range(0, 11) == 0); ecall = ($urandom_range(0, 11) == 0);
            ebreak = ($urandom_range(0, 11) == 0); mret = ($urandom_range(0, 5) == 0);
            iam = ($urandom_range(0, 11) == 0); lam = ($urandom_range(0, 11) == 0);
            sam = ($urandom_range(0, 11) == 0);
            mie = 1'($urandom); meie = 1'($urandom); mtie = 1'($urandom); msie = 1'($urandom);
            meip = ($urandom_range(0, 3) == 0); mtip = ($urandom_range(0, 3) == 0);
            msip = ($urandom_range(0, 3) == 0);
            tick();
            if (go_o[0] || ret_o[0])
                $display("txn rnd%0d go=%0d ret=%0d cause=%h", n, go_o[0], ret_o[0], cause_o[0]);
        end
        rst = 0; stl = 0;
        clear_flags();
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
